// File: rtl/ula_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU and the control unit that drives it:
// sel opcodes, FSM state encoding and NZCV bit positions inside cond.
package ula_multiciclo_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIM  = 2'd3
  } state_e;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ula_muldiv_seq.sv
// Iterative datapath: unsigned shift-add multiply / restoring divide, one bit per cycle.
// Operands captured on start; fim flags the last iteration, whose results appear on the outputs that same cycle.
module ula_muldiv_seq
  import ula_multiciclo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fim,
  output logic [WIDTH-1:0] produto,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto
);

  logic               r_busy;
  logic               r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;

  logic [WIDTH:0]     w_mul_sum;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // MUL: acc = {partial, multiplier}; add multiplicand on the LSB, then shift right with the carry.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // DIV: acc = {remainder, dividend/quotient}; the remainder stays below the divisor, so the
  // difference fits in WIDTH bits. A zero divisor always "fits": all-ones quotient, remainder = a.
  assign w_div_ge   = r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_opnd};
  assign w_div_diff = r_acc[2*WIDTH-2:WIDTH-1] - r_opnd;
  assign w_rem_nxt  = w_div_ge ? w_div_diff : r_acc[2*WIDTH-2:WIDTH-1];

  assign w_acc_nxt = r_op ? {w_rem_nxt, r_acc[WIDTH-2:0], w_div_ge}
                          : {w_mul_sum, r_acc[WIDTH-1:1]};

  assign fim       = r_busy && (r_cnt == CNT_W'(WIDTH-1));
  assign produto   = w_acc_nxt[WIDTH-1:0];
  assign quociente = w_acc_nxt[WIDTH-1:0];
  assign resto     = w_acc_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_op   <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opnd <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_op   <= op;
      r_cnt  <= '0;
      r_acc  <= {{WIDTH{1'b0}}, (op ? a : b)};
      r_opnd <= op ? b : a;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      if (fim) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: logic/add/sub finish in 1 cycle, MUL/DIV in WIDTH+1; done is a one-cycle pulse.
// Valid/ready handshake: in_ready only in IDLE; requests arriving while busy are dropped.
module ula_multiciclo
  import ula_multiciclo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resto,
  output logic [3:0]       cond,
  output logic             div_zero,
  output logic             done
);

  state_e           r_state;
  state_e           w_next_state;
  logic             r_done;
  logic             r_div_zero;
  logic             r_b_zero;
  logic [WIDTH-1:0] r_resultado;
  logic [WIDTH-1:0] r_resto;
  logic [3:0]       r_cond;

  logic             w_accept;
  logic             w_start_seq;
  logic             w_fim;
  logic             w_is_sub;
  logic             w_set_flags;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_op_res;
  logic [3:0]       w_flags;
  logic [WIDTH-1:0] w_produto;
  logic [WIDTH-1:0] w_quociente;
  logic [WIDTH-1:0] w_resto_seq;

  assign in_ready    = (r_state == ST_IDLE);
  assign w_accept    = in_valid & in_ready;
  assign w_start_seq = w_accept & is_iterative(sel);
  assign w_is_sub    = (sel == OP_SUB);
  assign w_set_flags = s & ((sel == OP_ADD) | (sel == OP_SUB));

  // SUB is a + ~b + 1, so the carry out is the ARM no-borrow flag (a >= b).
  assign w_b_eff = w_is_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

  always_comb begin
    w_op_res = '0;
    case (sel)
      OP_AND:         w_op_res = a & b;
      OP_XOR:         w_op_res = a ^ b;
      OP_OR:          w_op_res = a | b;
      OP_SUB, OP_ADD: w_op_res = w_sum[WIDTH-1:0];
      default:        w_op_res = '0;
    endcase
    w_flags         = '0;
    w_flags[FLAG_N] = w_sum[WIDTH-1];
    w_flags[FLAG_Z] = (w_sum[WIDTH-1:0] == '0);
    w_flags[FLAG_C] = w_sum[WIDTH];
    w_flags[FLAG_V] = w_is_sub ? ((a[WIDTH-1] != b[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]))
                               : ((a[WIDTH-1] == b[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]));
  end

  ula_muldiv_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start_seq),
    .op        (sel == OP_DIV),
    .a         (a),
    .b         (b),
    .fim       (w_fim),
    .produto   (w_produto),
    .quociente (w_quociente),
    .resto     (w_resto_seq)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (sel == OP_MUL)      w_next_state = ST_MUL;
          else if (sel == OP_DIV) w_next_state = ST_DIV;
          else                    w_next_state = ST_FIM;
        end
      end
      ST_MUL, ST_DIV: if (w_fim) w_next_state = ST_FIM;
      ST_FIM:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_b_zero    <= 1'b0;
      r_resultado <= '0;
      r_resto     <= '0;
      r_cond      <= '0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == ST_FIM);
      if (w_accept) r_b_zero <= (b == '0);
      if (w_accept && !is_iterative(sel)) begin
        r_resultado <= w_op_res;
        r_resto     <= '0;
        r_div_zero  <= 1'b0;
        if (w_set_flags) r_cond <= w_flags;
      end
      if (w_fim) begin
        if (r_state == ST_DIV) begin
          r_resultado <= r_b_zero ? {WIDTH{1'b1}} : w_quociente;
          r_resto     <= w_resto_seq;
          r_div_zero  <= r_b_zero;
        end else begin
          r_resultado <= w_produto;
          r_resto     <= '0;
          r_div_zero  <= 1'b0;
        end
      end
    end
  end

  assign resultado = r_resultado;
  assign resto     = r_resto;
  assign cond      = r_cond;
  assign div_zero  = r_div_zero;
  assign done      = r_done;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo (WIDTH=32): directed vector table, randomized ops against a
// plain-arithmetic reference model, and hand sequences for busy-time requests and mid-op reset.
module tb_ula_multiciclo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  sel = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        s = 1'b0;
  logic [31:0] resultado;
  logic [31:0] resto;
  logic [3:0]  cond;
  logic        div_zero;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  ula_multiciclo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .s         (s),
    .resultado (resultado),
    .resto     (resto),
    .cond      (cond),
    .div_zero  (div_zero),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic        vs;
    logic        poke;
    logic [31:0] res;
    logic [31:0] rem;
    logic        dz;
    logic [3:0]  cnd;
    int          lat;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: straight from the ALU rules, using native arithmetic operators.
  function automatic void model(input logic [3:0] op, input logic [31:0] ma, input logic [31:0] mb,
      input logic ms, input logic [3:0] c_in, output logic [31:0] r, output logic [31:0] rem,
      output logic dz, output logic [3:0] c_out, output int lat);
    logic [32:0] wide;
    logic [63:0] prod;
    r = '0; rem = '0; dz = 1'b0; c_out = c_in; lat = 1;
    case (op)
      4'd0: r = ma & mb;
      4'd1: r = ma ^ mb;
      4'd2: r = ma | mb;
      4'd3: begin
        r = ma - mb;
        if (ms) c_out = {r[31], r == 0, ma >= mb, (ma[31] != mb[31]) && (r[31] != ma[31])};
      end
      4'd4: begin
        wide = {1'b0, ma} + {1'b0, mb};
        r = wide[31:0];
        if (ms) c_out = {r[31], r == 0, wide[32], (ma[31] == mb[31]) && (r[31] != ma[31])};
      end
      4'd5: begin
        prod = {32'b0, ma} * {32'b0, mb};
        r = prod[31:0];
        lat = 33;
      end
      4'd6: begin
        lat = 33;
        if (mb == 0) begin r = '1; rem = ma; dz = 1'b1; end
        else begin r = ma / mb; rem = ma % mb; end
      end
      default: ;
    endcase
  endfunction

  // Issue one request when idle, scramble inputs after accept, wait (bounded) for done.
  task automatic do_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
      input logic i_s, input logic poke,
      output logic [31:0] o_res, output logic [31:0] o_rem, output logic o_dz,
      output logic [3:0] o_cond, output int lat, output int busy_bad,
      output logic rdy_at_done, output logic rdy_after);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    sel = op; a = ia; b = ib; s = i_s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sel = 4'($urandom); a = $urandom; b = $urandom; s = 1'($urandom);
    lat = 1;
    busy_bad = 0;
    while (!done && lat < 100) begin
      if (in_ready) busy_bad++;
      if (poke) in_valid = (lat == 5);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    o_res = resultado; o_rem = resto; o_dz = div_zero; o_cond = cond;
    rdy_at_done = in_ready;
    @(posedge clk); #1;
    rdy_after = in_ready;
  endtask

  logic [31:0] g_res, g_rem, e_res, e_rem;
  logic        g_dz, e_dz, g_rdy0, g_rdy1;
  logic [3:0]  g_cond, e_cond, m_cond;
  int          g_lat, e_lat, g_bad, done_seen;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b;
  logic        r_s;

  initial begin
    //          op     a             b             s     poke  res           rem           dz    cond     lat
    tbl[0]  = '{4'h4, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h80000000, 32'h0,        1'b0, 4'b1001, 1};
    tbl[1]  = '{4'h3, 32'h5,        32'h5,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 4'b0110, 1};
    tbl[2]  = '{4'h4, 32'h1,        32'h1,        1'b0, 1'b0, 32'h2,        32'h0,        1'b0, 4'b0110, 1};
    tbl[3]  = '{4'h5, 32'h0000FFFF, 32'h00010001, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b0110, 33};
    tbl[4]  = '{4'h6, 32'd100,      32'd7,        1'b0, 1'b0, 32'd14,       32'd2,        1'b0, 4'b0110, 33};
    tbl[5]  = '{4'h6, 32'd100,      32'd0,        1'b1, 1'b0, 32'hFFFFFFFF, 32'd100,      1'b1, 4'b0110, 33};
    tbl[6]  = '{4'h0, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 1'b0, 32'h30303030, 32'h0,        1'b0, 4'b0110, 1};
    tbl[7]  = '{4'h1, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b0, 1'b0, 32'hCCCCCCCC, 32'h0,        1'b0, 4'b0110, 1};
    tbl[8]  = '{4'h2, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b0, 1'b0, 32'hFCFCFCFC, 32'h0,        1'b0, 4'b0110, 1};
    tbl[9]  = '{4'h7, 32'h5,        32'h5,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 4'b0110, 1};
    tbl[10] = '{4'h3, 32'h3,        32'h5,        1'b1, 1'b0, 32'hFFFFFFFE, 32'h0,        1'b0, 4'b1000, 1};
    tbl[11] = '{4'h4, 32'hFFFFFFFF, 32'h1,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 4'b0110, 1};
    tbl[12] = '{4'h3, 32'h80000000, 32'h1,        1'b1, 1'b0, 32'h7FFFFFFF, 32'h0,        1'b0, 4'b0011, 1};
    tbl[13] = '{4'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h1,        32'h0,        1'b0, 4'b0011, 33};
    tbl[14] = '{4'h6, 32'd7,        32'd100,      1'b0, 1'b0, 32'd0,        32'd7,        1'b0, 4'b0011, 33};
    tbl[15] = '{4'h6, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b0011, 33};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset done", 32'(done), 32'h0);
    chk("reset resultado", resultado, 32'h0);
    chk("reset resto", resto, 32'h0);
    chk("reset cond", 32'(cond), 32'h0);
    chk("reset div_zero", 32'(div_zero), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].op, tbl[i].va, tbl[i].vb, tbl[i].vs, tbl[i].poke,
            g_res, g_rem, g_dz, g_cond, g_lat, g_bad, g_rdy0, g_rdy1);
      chk($sformatf("row%0d resultado", i), g_res, tbl[i].res);
      chk($sformatf("row%0d resto", i), g_rem, tbl[i].rem);
      chk($sformatf("row%0d div_zero", i), 32'(g_dz), 32'(tbl[i].dz));
      chk($sformatf("row%0d cond", i), 32'(g_cond), 32'(tbl[i].cnd));
      chk($sformatf("row%0d latency", i), 32'(g_lat), 32'(tbl[i].lat));
      chk($sformatf("row%0d in_ready while busy", i), 32'(g_bad), 32'h0);
      chk($sformatf("row%0d in_ready at done", i), 32'(g_rdy0), 32'h0);
      chk($sformatf("row%0d in_ready after done", i), 32'(g_rdy1), 32'h1);
    end

    m_cond = tbl[15].cnd;
    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 8));
      r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       r_b = 32'h0;
        1, 2:    r_b = 32'($urandom_range(1, 1000));
        default: r_b = 32'($urandom);
      endcase
      r_s = 1'($urandom);
      model(r_op, r_a, r_b, r_s, m_cond, e_res, e_rem, e_dz, e_cond, e_lat);
      do_op(r_op, r_a, r_b, r_s, 1'b0, g_res, g_rem, g_dz, g_cond, g_lat, g_bad, g_rdy0, g_rdy1);
      chk($sformatf("rand%0d op%0d resultado", i, r_op), g_res, e_res);
      chk($sformatf("rand%0d op%0d resto", i, r_op), g_rem, e_rem);
      chk($sformatf("rand%0d op%0d div_zero", i, r_op), 32'(g_dz), 32'(e_dz));
      chk($sformatf("rand%0d op%0d cond", i, r_op), 32'(g_cond), 32'(e_cond));
      chk($sformatf("rand%0d op%0d latency", i, r_op), 32'(g_lat), 32'(e_lat));
      m_cond = e_cond;
    end

    // Leave non-reset values on every output, then reset 10 cycles into a MUL.
    do_op(4'h3, 32'h3, 32'h5, 1'b1, 1'b0, g_res, g_rem, g_dz, g_cond, g_lat, g_bad, g_rdy0, g_rdy1);
    chk("pre-reset SUB cond", 32'(g_cond), 32'b1000);
    do_op(4'h6, 32'd100, 32'd0, 1'b0, 1'b0, g_res, g_rem, g_dz, g_cond, g_lat, g_bad, g_rdy0, g_rdy1);
    chk("pre-reset DIV0 resto", g_rem, 32'd100);
    @(negedge clk);
    sel = 4'h5; a = 32'h0000FFFF; b = 32'h00010001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-MUL busy", 32'(in_ready), 32'h0);
    reset = 1'b1;
    #1;
    chk("mid reset in_ready", 32'(in_ready), 32'h1);
    chk("mid reset done", 32'(done), 32'h0);
    chk("mid reset resultado", resultado, 32'h0);
    chk("mid reset resto", resto, 32'h0);
    chk("mid reset cond", 32'(cond), 32'h0);
    chk("mid reset div_zero", 32'(div_zero), 32'h0);
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || !in_ready) done_seen++;
    end
    chk("aborted MUL no done", 32'(done_seen), 32'h0);

    do_op(4'h4, 32'd2, 32'd3, 1'b0, 1'b0, g_res, g_rem, g_dz, g_cond, g_lat, g_bad, g_rdy0, g_rdy1);
    chk("post-reset ADD resultado", g_res, 32'd5);
    chk("post-reset ADD latency", 32'(g_lat), 32'd1);
    chk("post-reset ADD cond", 32'(g_cond), 32'h0);
    do_op(4'h5, 32'd3, 32'd4, 1'b0, 1'b0, g_res, g_rem, g_dz, g_cond, g_lat, g_bad, g_rdy0, g_rdy1);
    chk("post-reset MUL resultado", g_res, 32'd12);
    chk("post-reset MUL latency", 32'(g_lat), 32'd33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
